// File: rtl/operand_stepper_pkg.sv
// Shared definitions for the operand stepper: operand width, default wrap
// bound, debouncer state encoding and the wrapping step arithmetic.
package operand_stepper_pkg;

    localparam int OPERAND_W       = 4;
    localparam int DEFAULT_MAX_VAL = 8;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    // Count up, wrapping to 0 past the bound; an out-of-range loaded value also wraps to 0.
    function automatic logic [OPERAND_W-1:0] step_up(input logic [OPERAND_W-1:0] val,
                                                     input logic [OPERAND_W-1:0] max_val);
        return (val >= max_val) ? '0 : val + 1'b1;
    endfunction

    // Count down, wrapping to the bound below 0; an out-of-range loaded value drops to the bound.
    function automatic logic [OPERAND_W-1:0] step_dn(input logic [OPERAND_W-1:0] val,
                                                     input logic [OPERAND_W-1:0] max_val);
        return ((val == '0) || (val > max_val)) ? max_val : val - 1'b1;
    endfunction

endpackage

// File: rtl/operand_stepper_debouncer.sv
// button_debouncer: 2-FF synchronizer, debounce FSM with a disagreement
// counter, and a registered one-cycle step pulse on each accepted press.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module button_debouncer
    import operand_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_step
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
        $error("button_debouncer: invalid timing parameters");
    end

    logic [1:0]       r_sync;
    db_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step;

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    logic [HOLD_W-1:0] r_hold;
`endif

    logic w_sync_n;
    logic w_stable_n;
    logic w_differs;
    logic w_done;

    assign w_sync_n   = r_sync[1];
    assign w_stable_n = (r_state == RELEASED) || (r_state == PRESS_WAIT);
    assign w_differs  = (w_sync_n != w_stable_n);
    assign w_done     = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign o_step     = r_step;

    // Bring the raw button into the clock domain; reset value means "released".
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_btn_n};
        end
    end

    // Debounce FSM: count disagreeing cycles, flip the stable level after a full run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_step  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_hold  <= '0;
`endif
        end else begin
            r_step <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_hold <= '0;
`endif
            if (!w_differs) begin
                // Agreement ends any glitch: fall back to the origin state.
                r_cnt   <= '0;
                r_state <= w_stable_n ? RELEASED : PRESSED;
`ifdef AUTO_REPEAT_EN
                if (r_state == PRESSED) begin
                    if (r_hold == HOLD_W'(REPEAT_DELAY - 1)) begin
                        r_step <= 1'b1;
                        r_hold <= HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
`endif
            end else if (w_done) begin
                r_cnt   <= '0;
                r_state <= w_stable_n ? PRESSED : RELEASED;
                r_step  <= w_stable_n;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_state <= w_stable_n ? PRESS_WAIT : RELEASE_WAIT;
            end
        end
    end

endmodule

// File: rtl/operand_stepper.sv
// operand_stepper: debounced up/down stepping of a 4-bit wrapping operand
// with a direct switch load. OUT feeds the multiplier unchanged; CHANGED
// pulses for one cycle when OUT takes a new value.
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat while a button is held).
module operand_stepper
    import operand_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_VAL         = DEFAULT_MAX_VAL,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_btn_up,
    input  logic                 i_btn_dn,
    input  logic                 i_load,
    input  logic [OPERAND_W-1:0] i_sw,
    output logic [OPERAND_W-1:0] o_out,
    output logic                 o_changed
);

    localparam logic [OPERAND_W-1:0] MAX_V = OPERAND_W'(MAX_VAL);

    logic                 w_up_step;
    logic                 w_dn_step;
    logic [OPERAND_W-1:0] w_next;
    logic [OPERAND_W-1:0] r_out;
    logic                 r_changed;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_db_up (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn_n(i_btn_up),
        .o_step (w_up_step)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_db_dn (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn_n(i_btn_dn),
        .o_step (w_dn_step)
    );

    // Next operand: LOAD wins, simultaneous up+down cancels, then UP, then DN.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
        w_next = r_out;
        if (i_load) begin
            w_next = i_sw;
        end else if (w_up_step && w_dn_step) begin
            w_next = r_out;
        end else if (w_up_step) begin
            w_next = step_up(r_out, MAX_V);
        end else if (w_dn_step) begin
            w_next = step_dn(r_out, MAX_V);
        end
    end

    // Operand register and change pulse (only when the value really changes).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out     <= '0;
            r_changed <= 1'b0;
        end else begin
            r_out     <= w_next;
            r_changed <= (w_next != r_out);
        end
    end

    assign o_out     = r_out;
    assign o_changed = r_changed;

endmodule
